// File: rtl/decode_cycle_if.sv
// IF/ID, writeback, flush and ID/EX signal bundle around the RV32I decode stage.
// The decode stage takes the slave view. The surrounding pipeline (or a bench) takes the master view.
interface decode_cycle_if;
  logic [31:0] i_decode_pc_id;
  logic [31:0] i_decode_inst_id;
  logic        i_decode_insn_vld_id;
  logic        i_decode_flush;
  logic        i_decode_wb_en;
  logic [4:0]  i_decode_wb_addr;
  logic [31:0] i_decode_wb_data;
  logic        o_decode_load_use_stall;
  logic [31:0] o_decode_pc_ex;
  logic [31:0] o_decode_inst_ex;
  logic [31:0] o_decode_rs1_data_ex;
  logic [31:0] o_decode_rs2_data_ex;
  logic [31:0] o_decode_imm_ex;
  logic [4:0]  o_decode_rs1_addr_ex;
  logic [4:0]  o_decode_rs2_addr_ex;
  logic [4:0]  o_decode_rd_addr_ex;
  logic        o_decode_insn_vld_ex;

  modport master (
    output i_decode_pc_id, i_decode_inst_id, i_decode_insn_vld_id, i_decode_flush,
           i_decode_wb_en, i_decode_wb_addr, i_decode_wb_data,
    input  o_decode_load_use_stall, o_decode_pc_ex, o_decode_inst_ex,
           o_decode_rs1_data_ex, o_decode_rs2_data_ex, o_decode_imm_ex,
           o_decode_rs1_addr_ex, o_decode_rs2_addr_ex, o_decode_rd_addr_ex,
           o_decode_insn_vld_ex
  );

  modport slave (
    input  i_decode_pc_id, i_decode_inst_id, i_decode_insn_vld_id, i_decode_flush,
           i_decode_wb_en, i_decode_wb_addr, i_decode_wb_data,
    output o_decode_load_use_stall, o_decode_pc_ex, o_decode_inst_ex,
           o_decode_rs1_data_ex, o_decode_rs2_data_ex, o_decode_imm_ex,
           o_decode_rs1_addr_ex, o_decode_rs2_addr_ex, o_decode_rd_addr_ex,
           o_decode_insn_vld_ex
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with write-through bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode_cycle #(
  parameter logic [31:0] NOP_INST    = 32'h00000013,
  parameter logic [6:0]  LOAD_OPCODE = 7'b0000011
) (
  input logic           i_decode_clk,
  input logic           i_decode_reset,
  decode_cycle_if.slave bus
);

  logic [31:0] regs [32];

  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rd_id;
  logic [6:0]  opcode_id;
  logic [31:0] inst_id;
  logic        wb_write;
  logic [31:0] rs1_data_id;
  logic [31:0] rs2_data_id;
  logic [31:0] imm_id;
  logic        load_use;

  logic [31:0] pc_ex;
  logic [31:0] inst_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [31:0] imm_ex;
  logic [4:0]  rs1_addr_ex;
  logic [4:0]  rs2_addr_ex;
  logic [4:0]  rd_addr_ex;
  logic        vld_ex;

  assign inst_id   = bus.i_decode_inst_id;
  assign rs1_id    = inst_id[19:15];
  assign rs2_id    = inst_id[24:20];
  assign rd_id     = inst_id[11:7];
  assign opcode_id = inst_id[6:0];
  assign wb_write  = bus.i_decode_wb_en && (bus.i_decode_wb_addr != 5'd0);

  always_ff @(posedge i_decode_clk or posedge i_decode_reset) begin
    if (i_decode_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.i_decode_wb_addr] <= bus.i_decode_wb_data;
    end
  end

  // A same-cycle writeback to a source register is forwarded so Decode never sees stale data.
  always_comb begin
    rs1_data_id = regs[rs1_id];
    if (rs1_id == 5'd0) rs1_data_id = '0;
    else if (wb_write && (bus.i_decode_wb_addr == rs1_id)) rs1_data_id = bus.i_decode_wb_data;
  end

  always_comb begin
    rs2_data_id = regs[rs2_id];
    if (rs2_id == 5'd0) rs2_data_id = '0;
    else if (wb_write && (bus.i_decode_wb_addr == rs2_id)) rs2_data_id = bus.i_decode_wb_data;
  end

  always_comb begin
    imm_id = '0;
    case (opcode_id)
      7'b0010011, 7'b0000011, 7'b1100111:
        imm_id = {{20{inst_id[31]}}, inst_id[31:20]};
      7'b0100011:
        imm_id = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
      7'b1100011:
        imm_id = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm_id = {inst_id[31:12], 12'b0};
      7'b1101111:
        imm_id = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};
      default:
        imm_id = '0;
    endcase
  end

  // A flush discards the dependent instruction anyway, so it suppresses the stall.
  assign load_use = vld_ex && (inst_ex[6:0] == LOAD_OPCODE) && (rd_addr_ex != 5'd0) &&
                    bus.i_decode_insn_vld_id && ((rd_addr_ex == rs1_id) || (rd_addr_ex == rs2_id)) &&
                    !bus.i_decode_flush;

  always_ff @(posedge i_decode_clk or posedge i_decode_reset) begin
    if (i_decode_reset) begin
      pc_ex       <= '0;
      inst_ex     <= NOP_INST;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      rs1_addr_ex <= '0;
      rs2_addr_ex <= '0;
      rd_addr_ex  <= '0;
      vld_ex      <= 1'b0;
    end else if (bus.i_decode_flush || load_use) begin
      pc_ex       <= '0;
      inst_ex     <= NOP_INST;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      rs1_addr_ex <= '0;
      rs2_addr_ex <= '0;
      rd_addr_ex  <= '0;
      vld_ex      <= 1'b0;
    end else begin
      pc_ex       <= bus.i_decode_pc_id;
      inst_ex     <= inst_id;
      rs1_data_ex <= rs1_data_id;
      rs2_data_ex <= rs2_data_id;
      imm_ex      <= imm_id;
      rs1_addr_ex <= rs1_id;
      rs2_addr_ex <= rs2_id;
      rd_addr_ex  <= rd_id;
      vld_ex      <= bus.i_decode_insn_vld_id;
    end
  end

  assign bus.o_decode_load_use_stall = load_use;
  assign bus.o_decode_pc_ex          = pc_ex;
  assign bus.o_decode_inst_ex        = inst_ex;
  assign bus.o_decode_rs1_data_ex    = rs1_data_ex;
  assign bus.o_decode_rs2_data_ex    = rs2_data_ex;
  assign bus.o_decode_imm_ex         = imm_ex;
  assign bus.o_decode_rs1_addr_ex    = rs1_addr_ex;
  assign bus.o_decode_rs2_addr_ex    = rs2_addr_ex;
  assign bus.o_decode_rd_addr_ex     = rd_addr_ex;
  assign bus.o_decode_insn_vld_ex    = vld_ex;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: each stimulus cycle queues the hand-computed ID/EX contents
// expected after the next rising edge, and a monitor pops and compares them.
module tb_decode_cycle;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        vld;
  } exp_t;

  logic clk;
  logic rst;
  int   assert_count;
  int   fail_count;
  exp_t sb[$];

  decode_cycle_if dif ();

  decode_cycle dut (
    .i_decode_clk   (clk),
    .i_decode_reset (rst),
    .bus            (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [4:0] rs1a, input logic [31:0] rs1d,
                              input logic [4:0] rs2a, input logic [31:0] rs2d,
                              input logic [31:0] imm, input logic [4:0] rd, input logic vld);
    exp_t e;
    e.tag = tag; e.pc = pc; e.inst = inst; e.rs1a = rs1a; e.rs1d = rs1d;
    e.rs2a = rs2a; e.rs2d = rs2d; e.imm = imm; e.rd = rd; e.vld = vld;
    return e;
  endfunction

  function automatic exp_t bubble(input string tag);
    return mk(tag, 32'h0, 32'h00000013, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
  endfunction

  // Drives one IF/ID + writeback cycle, checks the combinational stall, then advances one edge.
  task automatic applyStimulus(input exp_t e, input logic [31:0] pc, input logic [31:0] inst,
                               input logic vld, input logic flush, input logic wb_en,
                               input logic [4:0] wa, input logic [31:0] wd, input logic exp_stall);
    dif.i_decode_pc_id       = pc;
    dif.i_decode_inst_id     = inst;
    dif.i_decode_insn_vld_id = vld;
    dif.i_decode_flush       = flush;
    dif.i_decode_wb_en       = wb_en;
    dif.i_decode_wb_addr     = wa;
    dif.i_decode_wb_data     = wd;
    sb.push_back(e);
    #1;
    checkOutput({e.tag, ".stall"}, {31'b0, dif.o_decode_load_use_stall}, {31'b0, exp_stall});
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, ".pc"},   dif.o_decode_pc_ex, e.pc);
        checkOutput({e.tag, ".inst"}, dif.o_decode_inst_ex, e.inst);
        checkOutput({e.tag, ".rs1a"}, {27'b0, dif.o_decode_rs1_addr_ex}, {27'b0, e.rs1a});
        checkOutput({e.tag, ".rs1d"}, dif.o_decode_rs1_data_ex, e.rs1d);
        checkOutput({e.tag, ".rs2a"}, {27'b0, dif.o_decode_rs2_addr_ex}, {27'b0, e.rs2a});
        checkOutput({e.tag, ".rs2d"}, dif.o_decode_rs2_data_ex, e.rs2d);
        checkOutput({e.tag, ".imm"},  dif.o_decode_imm_ex, e.imm);
        checkOutput({e.tag, ".rd"},   {27'b0, dif.o_decode_rd_addr_ex}, {27'b0, e.rd});
        checkOutput({e.tag, ".vld"},  {31'b0, dif.o_decode_insn_vld_ex}, {31'b0, e.vld});
      end
    end
  end

  initial begin : stimulus
    assert_count = 0;
    fail_count   = 0;
    rst = 1'b1;
    dif.i_decode_pc_id       = '0;
    dif.i_decode_inst_id     = '0;
    dif.i_decode_insn_vld_id = 1'b0;
    dif.i_decode_flush       = 1'b0;
    dif.i_decode_wb_en       = 1'b0;
    dif.i_decode_wb_addr     = '0;
    dif.i_decode_wb_data     = '0;
    @(posedge clk);
    #2;
    checkOutput("reset.inst", dif.o_decode_inst_ex, 32'h00000013);
    checkOutput("reset.vld",  {31'b0, dif.o_decode_insn_vld_ex}, 32'h0);
    checkOutput("reset.pc",   dif.o_decode_pc_ex, 32'h0);
    rst = 1'b0;

    // Valid instruction in ID/EX, with x5 written through the bypass before the reset.
    applyStimulus(mk("pre_rst", 32'h100, 32'h00028333, 5'd5, 32'h11111111, 5'd0, 32'h0, 32'h0, 5'd6, 1'b1),
                  32'h100, 32'h00028333, 1'b1, 1'b0, 1'b1, 5'd5, 32'h11111111, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst.inst", dif.o_decode_inst_ex, 32'h00000013);
    checkOutput("midrst.vld",  {31'b0, dif.o_decode_insn_vld_ex}, 32'h0);
    checkOutput("midrst.rd",   {27'b0, dif.o_decode_rd_addr_ex}, 32'h0);
    checkOutput("midrst.rs1d", dif.o_decode_rs1_data_ex, 32'h0);
    #2;
    rst = 1'b0;

    applyStimulus(mk("x5_cleared", 32'h104, 32'h00028333, 5'd5, 32'h0, 5'd0, 32'h0, 32'h0, 5'd6, 1'b1),
                  32'h104, 32'h00028333, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("invalid_cap", 32'h108, 32'h00000013, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0),
                  32'h108, 32'h00000013, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    applyStimulus(mk("add_x5", 32'h10C, 32'h00028333, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 32'h0, 5'd6, 1'b1),
                  32'h10C, 32'h00028333, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("wb_x0_same", 32'h110, 32'h00028333, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 32'h0, 5'd6, 1'b1),
                  32'h110, 32'h00028333, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    applyStimulus(mk("wb_x0_after", 32'h114, 32'h00028333, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 32'h0, 5'd6, 1'b1),
                  32'h114, 32'h00028333, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("addi_bypass", 32'h118, 32'hFFF38413, 5'd7, 32'h12345678, 5'd31, 32'h0, 32'hFFFFFFFF, 5'd8, 1'b1),
                  32'h118, 32'hFFF38413, 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0);
    applyStimulus(mk("wr_x2", 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0),
                  32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h00000022, 1'b0);

    // Load followed by a dependent add: exactly one bubble, then the add proceeds.
    applyStimulus(mk("lw_a", 32'h200, 32'h0000A483, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b1),
                  32'h200, 32'h0000A483, 1'b1, 1'b0, 1'b1, 5'd3, 32'h00000033, 1'b0);
    applyStimulus(bubble("lu_bubble"), 32'h204, 32'h00248533, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    applyStimulus(mk("lu_release", 32'h204, 32'h00248533, 5'd9, 32'h0, 5'd2, 32'h22, 32'h0, 5'd10, 1'b1),
                  32'h204, 32'h00248533, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("lw_b", 32'h208, 32'h0000A483, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b1),
                  32'h208, 32'h0000A483, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("no_hazard", 32'h20C, 32'h00218533, 5'd3, 32'h33, 5'd2, 32'h22, 32'h0, 5'd10, 1'b1),
                  32'h20C, 32'h00218533, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

    applyStimulus(mk("lw_c", 32'h210, 32'h0000A483, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b1),
                  32'h210, 32'h0000A483, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(bubble("flush_wins"), 32'h214, 32'h00248533, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

    applyStimulus(mk("beq", 32'h300, 32'hFE000CE3, 5'd0, 32'h0, 5'd0, 32'h0, 32'hFFFFFFF8, 5'd25, 1'b1),
                  32'h300, 32'hFE000CE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("jal", 32'h304, 32'h001000EF, 5'd0, 32'h0, 5'd1, 32'h0, 32'h00000800, 5'd1, 1'b1),
                  32'h304, 32'h001000EF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("lui", 32'h308, 32'hABCDE137, 5'd27, 32'h0, 5'd28, 32'h0, 32'hABCDE000, 5'd2, 1'b1),
                  32'h308, 32'hABCDE137, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(mk("sw", 32'h30C, 32'h0021A623, 5'd3, 32'h33, 5'd2, 32'h22, 32'h0000000C, 5'd12, 1'b1),
                  32'h30C, 32'h0021A623, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

    // Hazard through rs2 rather than rs1.
    applyStimulus(mk("lw_d", 32'h310, 32'h0000A483, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 1'b1),
                  32'h310, 32'h0000A483, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    applyStimulus(bubble("lu_rs2_bubble"), 32'h314, 32'h00910533, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    applyStimulus(mk("lu_rs2_release", 32'h314, 32'h00910533, 5'd2, 32'h22, 5'd9, 32'h0, 32'h0, 5'd10, 1'b1),
                  32'h314, 32'h00910533, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);

    dif.i_decode_insn_vld_id = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
